// File: rtl/esm_config_rx_if.sv
// AXI-Stream slave-side bundle for the ESM configuration receiver.
// The producer drives valid/data/last; the receiver drives ready.
interface esm_config_rx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  S_axis_ready;
  logic                  S_axis_valid;
  logic [DATA_WIDTH-1:0] S_axis_data;
  logic                  S_axis_last;

  modport master (
    input  S_axis_ready,
    output S_axis_valid,
    output S_axis_data,
    output S_axis_last
  );

  modport slave (
    output S_axis_ready,
    input  S_axis_valid,
    input  S_axis_data,
    input  S_axis_last
  );
endinterface

// File: rtl/esm_config_rx.sv
// Framed configuration receiver: decodes control messages into global enables/reset
// and forwards every other module's payload words on Module_config.
module esm_config_rx #(
  parameter int          AXI_DATA_WIDTH    = 32,
  parameter logic [31:0] MAGIC_NUM         = 32'h45534D43,
  parameter logic [7:0]  CONTROL_MODULE_ID = 8'h00
) (
  input  logic                S_axis_clk,
  input  logic                S_axis_resetn,
  esm_config_rx_if.slave      s_axis,
  output logic                Rst_out,
  output logic                Enable_status,
  output logic [1:0]          Enable_chan,
  output logic [1:0]          Enable_pdw,
  output logic [66:0]         Module_config
);

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                widx_q, widx_d;
  logic                      pfirst_q, pfirst_d;
  logic [31:0]               hdr_q, hdr_d;
  logic                      ready_q;
  logic                      rst_q, rst_d;
  logic                      stat_q, stat_d;
  logic [1:0]                chan_q, chan_d;
  logic [1:0]                pdw_q, pdw_d;
  logic [66:0]               mc_q, mc_d;

  logic [AXI_DATA_WIDTH-1:0] data_s;
  logic                      xfer_s;
  logic                      last_s;

  assign data_s = s_axis.S_axis_data;
  assign last_s = s_axis.S_axis_last;
  assign xfer_s = s_axis.S_axis_valid & ready_q;

  // State and output registers; every output returns to its reset value asynchronously.
  always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
    if (!S_axis_resetn) begin
      state_q  <= ST_HEADER;
      widx_q   <= 2'd0;
      pfirst_q <= 1'b0;
      hdr_q    <= 32'd0;
      ready_q  <= 1'b0;
      rst_q    <= 1'b1;
      stat_q   <= 1'b0;
      chan_q   <= 2'd0;
      pdw_q    <= 2'd0;
      mc_q     <= 67'd0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      pfirst_q <= pfirst_d;
      hdr_q    <= hdr_d;
      ready_q  <= 1'b1;
      rst_q    <= rst_d;
      stat_q   <= stat_d;
      chan_q   <= chan_d;
      pdw_q    <= pdw_d;
      mc_q     <= mc_d;
    end
  end

  // Next-state: walk header words, then payload; a bad magic discards through last.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    pfirst_d = pfirst_q;
    hdr_d    = hdr_q;
    case (state_q)
      ST_HEADER: begin
        if (xfer_s) begin
          if (widx_q == 2'd2) begin
            hdr_d = data_s;
          end else begin
            hdr_d = hdr_q;
          end
          if (last_s) begin
            state_d = ST_HEADER;
            widx_d  = 2'd0;
          end else if ((widx_q == 2'd0) && (data_s != MAGIC_NUM)) begin
            state_d = ST_DISCARD;
            widx_d  = 2'd0;
          end else if (widx_q == 2'd3) begin
            state_d  = ST_PAYLOAD;
            widx_d   = 2'd0;
            pfirst_d = 1'b1;
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (xfer_s) begin
          pfirst_d = 1'b0;
          if (last_s) begin
            state_d = ST_HEADER;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_DISCARD: begin
        if (xfer_s && last_s) begin
          state_d = ST_HEADER;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_HEADER;
        widx_d  = 2'd0;
      end
    endcase
  end

  // Outputs: control decode on payload word 0, otherwise forward each payload word.
  always_comb begin
    rst_d  = rst_q;
    stat_d = stat_q;
    chan_d = chan_q;
    pdw_d  = pdw_q;
    mc_d   = {1'b0, mc_q[65:0]};
    case (state_q)
      ST_PAYLOAD: begin
        if (xfer_s) begin
          if (hdr_q[31:24] == CONTROL_MODULE_ID) begin
            if ((hdr_q[23:16] == 8'h00) && pfirst_q) begin
              rst_d  = data_s[24];
              pdw_d  = data_s[17:16];
              chan_d = data_s[9:8];
              stat_d = data_s[0];
            end else begin
              rst_d = rst_q;
            end
          end else begin
            mc_d = {1'b1, pfirst_q, last_s, hdr_q, data_s};
          end
        end else begin
          mc_d = {1'b0, mc_q[65:0]};
        end
      end
      default: begin
        mc_d = {1'b0, mc_q[65:0]};
      end
    endcase
  end

  assign s_axis.S_axis_ready = ready_q;
  assign Rst_out             = rst_q;
  assign Enable_status       = stat_q;
  assign Enable_chan         = chan_q;
  assign Enable_pdw          = pdw_q;
  assign Module_config       = mc_q;

endmodule

// File: tb/tb_esm_config_rx.sv
// Directed and randomized bench for esm_config_rx; a message-level model predicts
// forwarded records and control state.
module tb_esm_config_rx;
  localparam logic [31:0] MAGIC = 32'h45534D43;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        rst_out, en_stat;
  logic [1:0]  en_chan, en_pdw;
  logic [66:0] mc;

  esm_config_rx_if #(.DATA_WIDTH(32)) axis ();

  esm_config_rx dut (
    .S_axis_clk    (clk),
    .S_axis_resetn (rstn),
    .s_axis        (axis),
    .Rst_out       (rst_out),
    .Enable_status (en_stat),
    .Enable_chan   (en_chan),
    .Enable_pdw    (en_pdw),
    .Module_config (mc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [66:0] obs_q[$];
  int          obs_cyc[$];
  logic [66:0] exp_q[$];
  logic [31:0] m_q[$];
  logic [31:0] tx_d[$];
  logic        tx_l[$];
  logic        exp_rst, exp_stat;
  logic [1:0]  exp_chan, exp_pdw;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mc[66] === 1'b1) begin
      obs_q.push_back(mc);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [66:0] o, input logic [66:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Whole-message rules: needs >4 words and the magic; module 0 type 0 sets controls.
  task automatic model_and_queue();
    logic [31:0] w2;
    logic [31:0] p0;
    int          n;
    n = m_q.size();
    if (n > 4 && m_q[0] == MAGIC) begin
      w2 = m_q[2];
      p0 = m_q[4];
      if (w2[31:24] == 8'h00) begin
        if (w2[23:16] == 8'h00) begin
          exp_rst  = p0[24];
          exp_pdw  = p0[17:16];
          exp_chan = p0[9:8];
          exp_stat = p0[0];
        end
      end else begin
        for (int i = 4; i < n; i++)
          exp_q.push_back({1'b1, (i == 4), (i == n - 1), w2, m_q[i]});
      end
    end
    for (int i = 0; i < n; i++) begin
      tx_d.push_back(m_q[i]);
      tx_l.push_back(i == n - 1);
    end
    m_q.delete();
  endtask

  task automatic hdr(input logic [31:0] w0, input logic [31:0] w2);
    m_q.delete();
    m_q.push_back(w0);
    m_q.push_back($urandom);
    m_q.push_back(w2);
    m_q.push_back($urandom);
  endtask

  task automatic add_payload(input int n);
    for (int i = 0; i < n; i++) m_q.push_back($urandom);
  endtask

  task automatic flush();
    while (tx_d.size() > 0) begin
      axis.S_axis_valid = 1'b1;
      axis.S_axis_data  = tx_d.pop_front();
      axis.S_axis_last  = tx_l.pop_front();
      @(posedge clk);
      #1;
    end
    axis.S_axis_valid = 1'b0;
    axis.S_axis_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    int n;
    chk({tag, "_count"}, 67'(obs_q.size()), 67'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_rec%0d", tag, i), obs_q[i], exp_q[i]);
    chk({tag, "_ctrl"}, {61'd0, rst_out, en_stat, en_chan, en_pdw},
        {61'd0, exp_rst, exp_stat, exp_chan, exp_pdw});
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    exp_rst  = 1'b1;
    exp_stat = 1'b0;
    exp_chan = 2'd0;
    exp_pdw  = 2'd0;
    chk("rst_mc", mc, 67'd0);
    chk("rst_ready", {66'd0, axis.S_axis_ready}, 67'd0);
    chk("rst_ctrl", {61'd0, rst_out, en_stat, en_chan, en_pdw}, {61'd0, 1'b1, 1'b0, 2'd0, 2'd0});
    axis.S_axis_valid = 1'b0;
    axis.S_axis_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("ready_pre", {66'd0, axis.S_axis_ready}, 67'd0);
    @(posedge clk);
    #1;
    chk("ready_post", {66'd0, axis.S_axis_ready}, 67'd1);
  endtask

  initial begin
    logic [31:0] w2;
    logic [7:0]  mid;
    int          kind;
    int          gap;

    axis.S_axis_valid = 1'b0;
    axis.S_axis_data  = 32'd0;
    axis.S_axis_last  = 1'b0;
    #1;
    do_reset();

    // Control message with Rst_out=1, then one clearing reset and enabling channels/PDW.
    hdr(MAGIC, 32'h00000000);
    m_q.push_back(32'h01000000);
    m_q.push_back(32'hDEADBEEF);
    model_and_queue();
    flush();
    check_all("ctrl1");
    hdr(MAGIC, 32'h00000000);
    m_q.push_back(32'h00030300);
    model_and_queue();
    flush();
    check_all("ctrl2");
    chk("ctrl2_direct", {61'd0, rst_out, en_stat, en_chan, en_pdw}, {61'd0, 1'b0, 1'b0, 2'b11, 2'b11});

    // Dwell entry of 7 words immediately followed by a second forwarded message.
    hdr(MAGIC, 32'h01010005);
    add_payload(7);
    model_and_queue();
    hdr(MAGIC, 32'h02030040);
    add_payload(3);
    model_and_queue();
    flush();
    gap = (obs_cyc.size() >= 8) ? (obs_cyc[7] - obs_cyc[6]) : -1;
    chk("b2b_gap", 67'(gap), 67'd5);
    check_all("dwell");

    // Bad magic control message, then a good one with no idle cycle.
    hdr(32'h12345678, 32'h00000000);
    m_q.push_back(32'h00000001);
    model_and_queue();
    hdr(MAGIC, 32'h00000000);
    m_q.push_back(32'h01010001);
    model_and_queue();
    flush();
    check_all("badmagic");

    // Short message ending on w2, then a normal forwarded message.
    m_q.delete();
    m_q.push_back(MAGIC);
    m_q.push_back($urandom);
    m_q.push_back(32'h01010005);
    model_and_queue();
    hdr(MAGIC, 32'h05000123);
    add_payload(2);
    model_and_queue();
    flush();
    check_all("short");

    // Set nonzero controls, then reset in the middle of payload word 3 of a forwarded message.
    hdr(MAGIC, 32'h00000000);
    m_q.push_back(32'h00020101);
    model_and_queue();
    flush();
    check_all("ctrl3");
    w2 = 32'h02000010;
    hdr(MAGIC, w2);
    for (int i = 0; i < 4; i++) tx_d.push_back(m_q[i]);
    for (int i = 0; i < 4; i++) tx_l.push_back(1'b0);
    m_q.delete();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] p;
      p = $urandom;
      tx_d.push_back(p);
      tx_l.push_back(1'b0);
      exp_q.push_back({1'b1, (i == 0), 1'b0, w2, p});
    end
    flush();
    axis.S_axis_valid = 1'b1;
    axis.S_axis_data  = $urandom;
    do_reset();
    check_all("midreset");
    hdr(MAGIC, 32'h03070777);
    add_payload(4);
    model_and_queue();
    flush();
    check_all("after_reset");

    // Randomized batches of back-to-back messages of mixed kinds.
    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < 4; k++) begin
        kind = $urandom_range(0, 5);
        mid  = 8'($urandom_range(1, 255));
        case (kind)
          0: begin hdr(MAGIC, {16'h0000, 16'($urandom)}); add_payload($urandom_range(1, 4)); end
          1: begin hdr(MAGIC, {8'h00, 8'($urandom_range(1, 255)), 16'($urandom)}); add_payload($urandom_range(1, 3)); end
          2: begin hdr(MAGIC, {mid, 24'($urandom)}); add_payload($urandom_range(1, 5)); end
          3: begin hdr(MAGIC + 32'd1 + ($urandom & 32'h7FFFFFFF), {mid, 24'($urandom)}); add_payload($urandom_range(0, 3)); end
          4: begin hdr(MAGIC, {mid, 24'($urandom)}); repeat ($urandom_range(0, 3)) void'(m_q.pop_back()); end
          default: begin hdr(MAGIC, {8'h01, 8'h01, 16'($urandom)}); add_payload($urandom_range(1, 7)); end
        endcase
        model_and_queue();
      end
      flush();
      check_all($sformatf("rand%0d", b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/esm_config_rx.md
# esm_config_rx

Single-clock AXI-Stream configuration receiver for the ESM receiver. It parses framed configuration messages arriving on a 32-bit slave stream and decodes control messages (module 0x00) into the global reset/enable outputs. All other messages (for example dwell entries and dwell programs for the dwell controller) are forwarded word-by-word on `Module_config`.

## Interface
- `AXI_DATA_WIDTH`, default 32: stream word width; only 32 is supported.
- `MAGIC_NUM`, default 32'h45534D43: required value of header word 0.
- `CONTROL_MODULE_ID`, default 8'h00: module id decoded locally.
- `S_axis_clk`  in  1: the single clock; all logic is on its rising edge.
- `S_axis_resetn`  in  1: asynchronous, active-low reset.
- `S_axis_ready`  out  1: stream ready.
- `S_axis_valid`  in  1: stream valid.
- `S_axis_data`  in  32: stream data.
- `S_axis_last`  in  1: last word of the message.
- `Rst_out`  out  1: downstream soft reset.
- `Enable_status`  out  1: status reporting enable.
- `Enable_chan`  out  2: channelizer enables; bit0 narrow, bit1 wide.
- `Enable_pdw`  out  2: PDW encoder enables; bit0 narrow, bit1 wide.
- `Module_config`  out  67: packed record, MSB first:
  - valid[1], first[1], last[1]
  - module_id[8], message_type[8], address[16]
  - data[32]

## Operation
- A transfer occurs on each cycle with `S_axis_valid && S_axis_ready`. `S_axis_ready` is held at 1 while out of reset; there is no backpressure.
- Message format, with word index counted from 0 and reset to 0 after every `last` word:
  - w0: magic number.
  - w1: sequence number. It is ignored and not checked.
  - w2: {module_id[31:24], message_type[23:16], address[15:0]}.
  - w3: padding, ignored.
  - w4 onward: payload.
- Receive FSM states: HEADER (w0..w3), PAYLOAD, DISCARD.
  - w0 != `MAGIC_NUM`: go to DISCARD. All words up to and including the `last` word are dropped, then return to HEADER.
  - Word with `last` during HEADER: drop the message, return to HEADER. No outputs change.
  - w2 is latched as module_id, message_type and address.
- Control message (module_id == `CONTROL_MODULE_ID`, message_type 0x00), payload word 0 only:
  - bit24 -> `Rst_out`
  - bits17:16 -> `Enable_pdw`
  - bits9:8 -> `Enable_chan`
  - bit0 -> `Enable_status`
  - Other bits and other payload words are ignored. Control messages are not forwarded.
  - A control module message with any other message_type is dropped.
- Any other module_id: each payload word is forwarded.
  - valid=1.
  - first=1 on payload word 0.
  - last=`S_axis_last`.
  - Header fields come from the latched w2.
  - data=the payload word.
- A `last` word that is also payload is forwarded with last=1. The FSM then returns to HEADER.
- Back-to-back messages with no idle cycle between them are supported.

## Timing
- Reset values:
  - `Rst_out`=1.
  - `Enable_status`=0, `Enable_chan`=0, `Enable_pdw`=0.
  - `Module_config`: all fields 0.
  - `S_axis_ready`=0.
  - FSM in HEADER, word index 0.
- `S_axis_ready` rises on the first clock after reset deassertion.
- Control outputs update on the clock edge that accepts payload word 0. They are visible 1 cycle after acceptance and hold until the next control message or reset.
- `Module_config` is registered with 1-cycle latency. valid is a 1-cycle pulse per accepted payload word. data/header fields may hold their last value when valid=0.
- Reset asserted mid-message: the partial message is discarded, and all outputs and the FSM return immediately to reset values.

## Test plan
- Reset release, then control msg {MAGIC, 0, 0x00000000, 0xDEADBEEF, 0x01000000, 0xDEADBEEF} -> `Rst_out`=1, all enables 0. Then payload 0x00030300 -> `Rst_out`=0, `Enable_chan`=2'b11, `Enable_pdw`=2'b11, `Enable_status`=0.
- Dwell entry msg with w2=0x01010005 and 7 payload words -> 7 valid pulses on `Module_config`:
  - module_id=0x01, message_type=0x01, address=0x0005.
  - first only on word 0, last only on word 6.
  - data matches the payload in order.
- Bad magic (w0=0x12345678) on a control msg carrying 0x00000001 -> outputs unchanged. Then a valid msg sent back-to-back is decoded correctly.
- Short msg, 3 words with `last` on w2 -> no `Module_config` pulse, no control change. The next message parses correctly.
- `S_axis_resetn` pulsed low during payload word 3 of a forwarded message -> valid stays 0. `Rst_out`=1, enables 0. The next full message is accepted normally.
- Two forwarded messages with no idle cycle -> second message's first=1 pulse occurs exactly 5 cycles after the first message's last pulse (4 header words, then 1-cycle output register).
